if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, the instruction word presented when empty or after flush.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  fetch stage offers instruction.
REQ-005 The block SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-006 The block SHALL have port in_instr  input  32  fetched instruction word.
REQ-007 The block SHALL have port in_pc4  input  32  PC+4 of the fetched instruction.
REQ-008 The block SHALL have port flush  input  1  synchronous discard of all held entries (branch/jump taken).
REQ-009 The block SHALL have port out_valid  output  1  head entry valid for decode.
REQ-010 The block SHALL have port out_ready  input  1  decode consumes head entry.
REQ-011 The block SHALL have port out_instr  output  32  head instruction word.
REQ-012 The block SHALL have port out_pc4  output  32  head PC+4.
REQ-013 The block SHALL have ports out_opcode  output  6 (instr[31:26]); out_rs  output  5 (instr[25:21]); out_rt  output  5 (instr[20:16]); out_rd  output  5 (instr[15:11]).
REQ-014 The block SHALL have port out_imm  output  16  instr[15:0], driven to the sign-extension stage.
REQ-015 The block SHALL have port count  output  2  entries held (0..2).

Function
REQ-016 Storage SHALL be a 2-entry FIFO of {instr, pc4} with 1-bit write and read pointers wrapping 1->0.
REQ-017 in_ready SHALL equal (count != 2), derived from registered state only; no combinational path from out_ready or in_valid.
REQ-018 Accept SHALL occur when in_valid && in_ready && !flush: entry written at write pointer, pointer advances.
REQ-019 Release SHALL occur when out_valid && out_ready && !flush: read pointer advances.
REQ-020 out_valid SHALL equal (count != 0); latency accept-to-out_valid SHALL be exactly 1 cycle.
REQ-021 Simultaneous accept and release at count 1 SHALL leave count at 1 with order preserved; at count 2 no accept occurs (in_ready 0), release alone gives count 1.
REQ-022 Release at count 0 SHALL be ignored; count SHALL never underflow or exceed 2.
REQ-023 out_instr/out_pc4 SHALL be the head entry when count != 0, else NOP_INSTR and 32'h0; field outputs SHALL always be slices of out_instr.
REQ-024 flush SHALL override accept and release in the same cycle: next cycle count 0, both pointers 0, same-cycle input dropped.
REQ-025 Entries SHALL leave in the order accepted; no entry duplicated or lost absent flush.

Reset
REQ-026 On rst_n low, immediately and independent of clk: count 0, pointers 0, storage words NOP_INSTR/32'h0, out_valid 0, in_ready 1, out_instr NOP_INSTR, out_imm NOP_INSTR[15:0].
REQ-027 Reset asserted mid-operation SHALL discard all held entries without waiting for a clock edge; first accept possible on the first rising edge with rst_n high.

Verification
REQ-028 Pass-through: in 0x2008_FFFC/pc4 0x0000_0004, out_ready 1 -> next cycle out_valid 1, out_opcode 6'h08, out_rt 5'd8, out_imm 16'hFFFC, count 1.
REQ-029 Fill/backpressure: out_ready 0, three consecutive offers A,B,C -> A,B accepted, count 2, in_ready 0, C held by source; out_ready 1 -> A then B then C in order.
REQ-030 Simultaneous: count 1 holding A, accept B and release A same cycle -> count 1, head B.
REQ-031 Flush: count 2, flush with in_valid 1 and out_ready 1 -> next cycle count 0, out_valid 0, out_instr NOP_INSTR, offered word not stored.
REQ-032 Async reset: count 2, drop rst_n between edges -> out_valid 0 and count 0 before next edge; release -> accepts normally.
REQ-033 Underflow: count 0, out_ready 1 for 4 cycles -> count stays 0, out_valid 0.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a two-entry FIFO of {instr, pc4} between fetch and decode,
// with a taken-branch flush and NOP presentation whenever the buffer is empty.
module if_id_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [15:0] out_imm,
  output logic [1:0]  count
);

  logic [31:0] instrMem_q [2];
  logic [31:0] pc4Mem_q   [2];
  logic        wrPtr_q, wrPtr_d;
  logic        rdPtr_q, rdPtr_d;
  logic [1:0]  count_q, count_d;
  logic        doAccept, doRelease;

  // Handshake flags come from registered occupancy only, so in_ready never
  // depends combinationally on the decode side.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign doAccept  = in_valid && in_ready && !flush;
  assign doRelease = out_valid && out_ready && !flush;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = 1'b0;
      rdPtr_d = 1'b0;
      count_d = 2'd0;
    end else begin
      if (doAccept)  wrPtr_d = ~wrPtr_q;
      if (doRelease) rdPtr_d = ~rdPtr_q;
      case ({doAccept, doRelease})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Flush leaves stale words in storage; they are unreachable once count is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        instrMem_q[i] <= NOP_INSTR;
        pc4Mem_q[i]   <= 32'h0;
      end
    end else if (doAccept) begin
      instrMem_q[wrPtr_q] <= in_instr;
      pc4Mem_q[wrPtr_q]   <= in_pc4;
    end
  end

  assign out_instr  = out_valid ? instrMem_q[rdPtr_q] : NOP_INSTR;
  assign out_pc4    = out_valid ? pc4Mem_q[rdPtr_q]   : 32'h0;
  assign out_opcode = out_instr[31:26];
  assign out_rs     = out_instr[25:21];
  assign out_rt     = out_instr[20:16];
  assign out_rd     = out_instr[15:11];
  assign out_imm    = out_instr[15:0];
  assign count      = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: a queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'hFC00_0ABC;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [15:0] out_imm;
  logic [1:0]  count;

  int vectorCount = 0;
  int missCount   = 0;
  bit checkEn     = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t modelQ[$];

  if_id_buffer #(.NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc4     (in_pc4),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc4    (out_pc4),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge; they are sampled at the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc4    = pc4;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Model: FIFO of at most two entries; flush empties it, reset empties it at once.
  always @(negedge rst_n) modelQ.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        modelQ.delete();
      end else begin
        bit rel;
        bit acc;
        rel = (modelQ.size() > 0) && out_ready;
        acc = in_valid && (modelQ.size() < 2);
        if (rel) void'(modelQ.pop_front());
        if (acc) modelQ.push_back('{instr: in_instr, pc4: in_pc4});
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      logic [31:0] expInstr;
      logic [31:0] expPc4;
      expInstr = (modelQ.size() > 0) ? modelQ[0].instr : NOP;
      expPc4   = (modelQ.size() > 0) ? modelQ[0].pc4   : 32'h0;
      checkOutput("count",     32'(count),      32'(modelQ.size()));
      checkOutput("out_valid", 32'(out_valid),  32'(modelQ.size() != 0));
      checkOutput("in_ready",  32'(in_ready),   32'(modelQ.size() != 2));
      checkOutput("out_instr", out_instr,       expInstr);
      checkOutput("out_pc4",   out_pc4,         expPc4);
      checkOutput("out_opcode",32'(out_opcode), 32'(expInstr >> 26));
      checkOutput("out_rs",    32'(out_rs),     (expInstr >> 21) & 32'h1F);
      checkOutput("out_rt",    32'(out_rt),     (expInstr >> 16) & 32'h1F);
      checkOutput("out_rd",    32'(out_rd),     (expInstr >> 11) & 32'h1F);
      checkOutput("out_imm",   32'(out_imm),    expInstr & 32'hFFFF);
    end
  end

  localparam logic [31:0] A = 32'h8C22_0010;
  localparam logic [31:0] B = 32'h0043_2020;
  localparam logic [31:0] C = 32'h1085_FFF0;
  localparam logic [31:0] D = 32'h2108_0001;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = 32'h0; in_pc4 = 32'h0;
    out_ready = 1'b0; flush = 1'b0;
    #1;
    checkOutput("rst_count",  32'(count),     32'd0);
    checkOutput("rst_valid",  32'(out_valid), 32'd0);
    checkOutput("rst_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_instr",  out_instr,      NOP);
    checkOutput("rst_imm",    32'(out_imm),   32'h0ABC);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkEn = 1'b1;

    // Pass-through
    applyStimulus(1'b1, 32'h2008_FFFC, 32'h0000_0004, 1'b1, 1'b0);
    checkOutput("pt_valid",  32'(out_valid),  32'd1);
    checkOutput("pt_opcode", 32'(out_opcode), 32'h08);
    checkOutput("pt_rt",     32'(out_rt),     32'd8);
    checkOutput("pt_imm",    32'(out_imm),    32'hFFFC);
    checkOutput("pt_count",  32'(count),      32'd1);
    checkOutput("pt_pc4",    out_pc4,         32'h0000_0004);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("pt_drain",  32'(count),      32'd0);

    // Fill and backpressure; C stays offered until accepted
    applyStimulus(1'b1, A, 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, B, 32'h104, 1'b0, 1'b0);
    checkOutput("fill_count", 32'(count),    32'd2);
    checkOutput("fill_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, C, 32'h108, 1'b0, 1'b0);
    checkOutput("fill_hold",  out_instr,     A);
    applyStimulus(1'b1, C, 32'h108, 1'b1, 1'b0);
    checkOutput("drain_B",    out_instr,     B);
    checkOutput("drain_cnt1", 32'(count),    32'd1);
    applyStimulus(1'b1, C, 32'h108, 1'b1, 1'b0);
    checkOutput("drain_C",    out_instr,     C);
    checkOutput("drain_pc4C", out_pc4,       32'h108);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain_empty",32'(count),    32'd0);

    // Simultaneous accept and release at count 1
    applyStimulus(1'b1, A, 32'h200, 1'b0, 1'b0);
    applyStimulus(1'b1, B, 32'h204, 1'b1, 1'b0);
    checkOutput("sim_count", 32'(count), 32'd1);
    checkOutput("sim_head",  out_instr,  B);

    // Flush with fetch and decode both active
    applyStimulus(1'b1, C, 32'h208, 1'b0, 1'b0);
    checkOutput("pre_flush", 32'(count), 32'd2);
    applyStimulus(1'b1, D, 32'h20C, 1'b1, 1'b1);
    checkOutput("fl_count", 32'(count),     32'd0);
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_instr", out_instr,      NOP);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("fl_dropped", 32'(count),   32'd0);

    // Asynchronous reset between edges
    applyStimulus(1'b1, A, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, B, 32'h304, 1'b0, 1'b0);
    checkOutput("ar_pre", 32'(count), 32'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_count", 32'(count),     32'd0);
    checkOutput("ar_instr", out_instr,      NOP);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, D, 32'h400, 1'b0, 1'b0);
    checkOutput("ar_accept", out_instr,  D);
    checkOutput("ar_count1", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Underflow: decode ready with nothing held
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("uf_count", 32'(count),     32'd0);
      checkOutput("uf_valid", 32'(out_valid), 32'd0);
    end

    // Streaming burst with intermittent decode stalls
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'h1000_0000 + 32'(i * 7), 32'(i * 4), 1'(i % 3 != 0), 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("burst_empty", 32'(count), 32'd0);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
